// File: rtl/booth_seq_multiplier_if.sv
// Start/busy/done handshake and operand/result bus for booth_seq_multiplier.
interface booth_seq_multiplier_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic                   start;
  logic [WIDTH-1:0]       multiplicand;
  logic [WIDTH-1:0]       multiplier;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth multiplier: one add/sub + arithmetic shift per clock,
// signed WIDTH x WIDTH -> 2*WIDTH product, start/busy/done handshake.
module booth_seq_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  booth_seq_multiplier_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [WIDTH:0]     a_q, a_d;
  logic [WIDTH:0]     mx_q, mx_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               q1_q, q1_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic               sub, addsub;
  logic [WIDTH:0]     addend, sum, a_step, a_sh;
  logic [WIDTH-1:0]   q_sh;

  // Shared adder: subtraction is A + ~Mx + 1; A carries a guard bit so -2^(W-1) steps cannot overflow.
  always_comb begin
    sub    = q_q[0] & ~q1_q;
    addsub = q_q[0] ^ q1_q;
    addend = mx_q ^ {(WIDTH + 1){sub}};
    sum    = a_q + addend + {{WIDTH{1'b0}}, sub};
    a_step = addsub ? sum : a_q;
    a_sh   = {a_step[WIDTH], a_step[WIDTH:1]};
    q_sh   = {a_step[0], q_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    mx_d    = mx_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = '0;
          mx_d    = {bus.multiplicand[WIDTH-1], bus.multiplicand};
          q_d     = bus.multiplier;
          q1_d    = 1'b0;
          cnt_d   = CW'(WIDTH);
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        a_d   = a_sh;
        q_d   = q_sh;
        q1_d  = q_q[0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          prod_d  = {a_sh[WIDTH-1:0], q_sh};
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      mx_q    <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      mx_q    <= mx_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign bus.busy    = (state_q == S_CALC);
  assign bus.done    = (state_q == S_DONE);
  assign bus.product = prod_q;
endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Bench for booth_seq_multiplier: directed table at WIDTH=8, handshake corner
// sequences, and randomized WIDTH=16 products against a plain signed multiply.
module tb_booth_seq_multiplier;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  booth_seq_multiplier_if #(.WIDTH(8))  b8 ();
  booth_seq_multiplier_if #(.WIDTH(16)) b16 ();

  booth_seq_multiplier #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));
  booth_seq_multiplier #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  m;
    logic [7:0]  q;
    logic [15:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mul8(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
  endfunction

  function automatic logic [31:0] mul16(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
  endfunction

  // Called at a sample point (#1 after an edge) with the DUT idle; returns at a sample point, DUT idle again.
  task automatic op8(input logic [7:0] m, input logic [7:0] q,
                     output logic [15:0] p, output int lat, output int bsy);
    b8.start = 1'b1; b8.multiplicand = m; b8.multiplier = q;
    @(posedge clk); #1;
    b8.start = 1'b0; b8.multiplicand = 8'($urandom); b8.multiplier = 8'($urandom);
    lat = 0; bsy = 0;
    while (!b8.done && lat < 40) begin
      if (b8.busy) bsy++;
      @(posedge clk); #1;
      lat++;
    end
    p = b8.product;
    chk("w8_busy_done_overlap", {b8.busy, b8.done}, 2'b01);
    @(posedge clk); #1;
    chk("w8_done_fall", {b8.busy, b8.done}, 2'b00);
  endtask

  task automatic op16(input logic [15:0] m, input logic [15:0] q,
                      output logic [31:0] p, output int lat);
    b16.start = 1'b1; b16.multiplicand = m; b16.multiplier = q;
    @(posedge clk); #1;
    b16.start = 1'b0; b16.multiplicand = 16'($urandom); b16.multiplier = 16'($urandom);
    lat = 0;
    while (!b16.done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    p = b16.product;
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 9))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'hFFFF;
      3: return 16'h0000;
      4: return 16'h8001;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[7];
    logic [15:0] p8;
    logic [31:0] p16;
    logic [7:0]  hm[40];
    logic [7:0]  hq[40];
    logic [15:0] m16, q16;
    int          lat, bsy, ndone, idx;
    bit          seen;

    tbl[0] = '{8'd7,   8'd3,   16'h0015};
    tbl[1] = '{8'hFB,  8'h03,  16'hFFF1};
    tbl[2] = '{8'h03,  8'hFB,  16'hFFF1};
    tbl[3] = '{8'h00,  8'h80,  16'h0000};
    tbl[4] = '{8'h80,  8'h80,  16'h4000};
    tbl[5] = '{8'h80,  8'h7F,  16'hC080};
    tbl[6] = '{8'h7F,  8'h7F,  16'h3F01};

    b8.start = 1'b0;  b8.multiplicand = '0;  b8.multiplier = '0;
    b16.start = 1'b0; b16.multiplicand = '0; b16.multiplier = '0;
    rst = 1'b1;
    #2;
    chk("reset_w8",  {b8.busy, b8.done, b8.product}, '0);
    chk("reset_w16", {b16.busy, b16.done, b16.product}, '0);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      op8(tbl[i].m, tbl[i].q, p8, lat, bsy);
      chk($sformatf("tbl%0d_product", i), p8, tbl[i].exp);
      chk($sformatf("tbl%0d_latency", i), lat, 8);
      chk($sformatf("tbl%0d_busy_cycles", i), bsy, 8);
    end

    // start held high with operands changing each cycle: accepts every 10 edges.
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      hm[c] = 8'($urandom); hq[c] = 8'($urandom);
      b8.start = 1'b1; b8.multiplicand = hm[c]; b8.multiplier = hq[c];
      @(posedge clk); #1;
      if (b8.done) begin
        idx = (c >= 8) ? c - 8 : 0;
        chk("hold_done_edge", c, 8 + 10 * ndone);
        chk("hold_product", b8.product, mul8(hm[idx], hq[idx]));
        ndone++;
      end
    end
    b8.start = 1'b0;
    chk("hold_done_count", ndone, 4);
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset mid-CALC, between edges.
    b8.start = 1'b1; b8.multiplicand = 8'd9; b8.multiplier = 8'd11;
    @(posedge clk); #1;
    b8.start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_busy",    b8.busy, 1'b0);
    chk("abort_done",    b8.done, 1'b0);
    chk("abort_product", b8.product, 16'h0000);
    #10 rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (b8.done || b8.busy) seen = 1'b1;
    end
    chk("abort_no_done", seen, 1'b0);
    op8(8'hF6, 8'd13, p8, lat, bsy);
    chk("post_abort_product", p8, 16'hFF7E);
    chk("post_abort_latency", lat, 8);

    for (int i = 0; i < 2000; i++) begin
      m16 = pick16();
      q16 = pick16();
      op16(m16, q16, p16, lat);
      chk("rand16_product", p16, mul16(m16, q16));
      chk("rand16_latency", lat, 16);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
